// File: rtl/mem_access_stage.sv
// RV32I memory stage: data-memory access over a ready-based bus, wait-state stalls,
// timeout abort and the MEM/WB register. Define MEM_SUBWORD_EN for byte/halfword access.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Ctl_MemtoReg_in,
  input  logic        Ctl_RegWrite_in,
  input  logic        Ctl_MemRead_in,
  input  logic        Ctl_MemWrite_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic [4:0]  Rd_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] ALUresult_in,
  input  logic [31:0] ReadData2_in,
  input  logic [31:0] PC_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        bus_err_out,
  output logic [31:0] mem_fwd_data,
  output logic        Ctl_MemtoReg_out,
  output logic        Ctl_RegWrite_out,
  output logic        jal_out,
  output logic        jalr_out,
  output logic [4:0]  Rd_out,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALUresult_out,
  output logic [31:0] PC_out
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic        access;
  logic        timeout_hit;
  logic        req_raw;
  logic        stall_raw;
  logic        capture;
  logic        abort;
  logic [31:0] load_data;

  assign access       = Ctl_MemRead_in | Ctl_MemWrite_in;
  assign dmem_we      = Ctl_MemWrite_in;
  assign dmem_addr    = {ALUresult_in[31:2], 2'b00};
  assign mem_fwd_data = ALUresult_in;
  assign timeout_hit  = (state == S_WAIT) && (wait_cnt == TMO_LAST) && !dmem_ready;

  // Request and stall are killed combinationally while reset is held low
  assign dmem_req  = req_raw & reset;
  assign stall_out = stall_raw & reset;

`ifdef MEM_SUBWORD_EN
  logic [1:0]  lane;
  logic [31:0] lane_rdata;

  // Lane offset is the low address bits masked to the access size (misaligned is not trapped)
  always_comb begin
    case (funct3_in[1:0])
      2'b00:   lane = ALUresult_in[1:0];
      2'b01:   lane = {ALUresult_in[1], 1'b0};
      default: lane = 2'b00;
    endcase
  end

  assign lane_rdata = dmem_rdata >> {lane, 3'b000};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = ReadData2_in;
    case (funct3_in[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << lane;
        dmem_wdata = {24'd0, ReadData2_in[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        dmem_be    = 4'b0011 << lane;
        dmem_wdata = {16'd0, ReadData2_in[15:0]} << {lane, 3'b000};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3_in)
      3'b000:  load_data = {{24{lane_rdata[7]}}, lane_rdata[7:0]};
      3'b100:  load_data = {24'd0, lane_rdata[7:0]};
      3'b001:  load_data = {{16{lane_rdata[15]}}, lane_rdata[15:0]};
      3'b101:  load_data = {16'd0, lane_rdata[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end
`else
  logic unused_funct3;
  assign unused_funct3 = ^funct3_in;
  assign dmem_be       = 4'b1111;
  assign dmem_wdata    = ReadData2_in;
  assign load_data     = dmem_rdata;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (access && !dmem_ready) state_next = S_WAIT;
      S_WAIT: if (dmem_ready || timeout_hit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (access) begin
          req_raw = 1'b1;
          if (dmem_ready) capture   = 1'b1;
          else            stall_raw = 1'b1;
        end else begin
          capture = 1'b1;
        end
      end
      S_WAIT: begin
        req_raw = 1'b1;
        if (dmem_ready)       capture   = 1'b1;
        else if (timeout_hit) abort     = 1'b1;
        else                  stall_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter sits at zero in IDLE so the first WAIT cycle always sees 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                wait_cnt <= 8'd0;
    else if (state == S_IDLE)  wait_cnt <= 8'd0;
    else                       wait_cnt <= wait_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     bus_err_out <= 1'b0;
    else if (abort) bus_err_out <= 1'b1;
  end

  // Stall and abort cycles both insert a bubble; data fields keep their last values
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      jal_out          <= 1'b0;
      jalr_out         <= 1'b0;
      Rd_out           <= 5'd0;
      ReadData_out     <= 32'd0;
      ALUresult_out    <= 32'd0;
      PC_out           <= 32'd0;
    end else if (capture) begin
      Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
      Ctl_RegWrite_out <= Ctl_RegWrite_in;
      jal_out          <= jal_in;
      jalr_out         <= jalr_in;
      Rd_out           <= Rd_in;
      ReadData_out     <= Ctl_MemRead_in ? load_data : 32'd0;
      ALUresult_out    <= ALUresult_in;
      PC_out           <= PC_in;
    end else begin
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      jal_out          <= 1'b0;
      jalr_out         <= 1'b0;
    end
  end

endmodule
